// File: rtl/viterbi_traceback_unit_if.sv
// Handshake bundle between the ACS array, the traceback unit and the bit sink.
// Carries column decisions and frame control in, decoded bits and status out.
interface viterbi_traceback_unit_if #(
    parameter int unsigned K = 3
);
    localparam int unsigned NUM_ST = 1 << (K - 1);

    logic              en_td;
    logic [NUM_ST-1:0] i_dec;
    logic              i_last;
    logic              i_zero_term;
    logic [K-2:0]      i_tb_st;
    logic              o_bit;
    logic              o_valid;
    logic              o_first;
    logic              o_last;
    logic              o_busy;
    logic              o_drop;
    logic              o_ovf;

    modport master (
        output en_td, i_dec, i_last, i_zero_term, i_tb_st,
        input  o_bit, o_valid, o_first, o_last, o_busy, o_drop, o_ovf
    );

    modport slave (
        input  en_td, i_dec, i_last, i_zero_term, i_tb_st,
        output o_bit, o_valid, o_first, o_last, o_busy, o_drop, o_ovf
    );
endinterface

// File: rtl/viterbi_traceback_unit.sv
// Survivor memory and traceback for a radix-2 Viterbi decoder: stores one
// decision bit per state per column, traces back at frame end, emits bits in time order.
module viterbi_traceback_unit #(
    parameter int unsigned K     = 3,
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    viterbi_traceback_unit_if.slave bus
);
    localparam int unsigned NUM_ST = 1 << (K - 1);
    localparam int unsigned SW     = K - 1;
    localparam int unsigned AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {WR, TRACE, OUT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     last_ptr;
    logic [AW-1:0]     ptr;
    logic [SW-1:0]     cur;
    logic [DEPTH-1:0]  bitbuf;
    logic [NUM_ST-1:0] mem [DEPTH];

    logic o_bit, o_valid, o_first, o_last, o_busy, o_drop, o_ovf;

    logic wr_full;
    assign wr_full = (wptr == AW'(DEPTH - 1));

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            WR:      if (bus.en_td && (bus.i_last || wr_full)) state_nxt = TRACE;
            TRACE:   if (ptr == '0) state_nxt = OUT;
            OUT:     if (ptr == last_ptr) state_nxt = WR;
            default: state_nxt = WR;
        endcase
    end

    // Survivor store; contents are don't-care across reset
    always_ff @(posedge clk) begin
        if (state == WR && bus.en_td) mem[wptr] <= bus.i_dec;
    end

    // State register, traceback datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WR;
            wptr     <= '0;
            last_ptr <= '0;
            ptr      <= '0;
            cur      <= '0;
            bitbuf   <= '0;
            o_bit    <= 1'b0;
            o_valid  <= 1'b0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_drop   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_busy  <= (state_nxt != WR);
            o_drop  <= bus.en_td && (state != WR);
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            case (state)
                WR: begin
                    if (bus.en_td) begin
                        wptr <= wptr + AW'(1);
                        if (wptr == '0) o_ovf <= 1'b0;
                        if (bus.i_last) begin
                            last_ptr <= wptr;
                            ptr      <= wptr;
                            cur      <= bus.i_zero_term ? '0 : bus.i_tb_st;
                        end else if (wr_full) begin
                            // Frame ran out of memory: close it and trace from the best state
                            last_ptr <= wptr;
                            ptr      <= wptr;
                            cur      <= bus.i_tb_st;
                            o_ovf    <= 1'b1;
                        end
                    end
                end
                TRACE: begin
                    bitbuf[ptr] <= cur[SW-1];
                    cur         <= {cur[SW-2:0], mem[ptr][cur]};
                    if (ptr != '0) ptr <= ptr - AW'(1);
                end
                OUT: begin
                    o_bit   <= bitbuf[ptr];
                    o_valid <= 1'b1;
                    o_first <= (ptr == '0);
                    o_last  <= (ptr == last_ptr);
                    if (ptr == last_ptr) wptr <= '0;
                    else                 ptr  <= ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_bit   = o_bit;
    assign bus.o_valid = o_valid;
    assign bus.o_first = o_first;
    assign bus.o_last  = o_last;
    assign bus.o_busy  = o_busy;
    assign bus.o_drop  = o_drop;
    assign bus.o_ovf   = o_ovf;
endmodule

// File: tb/tb_viterbi_traceback_unit.sv
// Directed bench for viterbi_traceback_unit (K=3, DEPTH=8): frame table with
// hand-traced expected bits, plus drop, overflow and mid-output reset sequences.
module tb_viterbi_traceback_unit;
    localparam int unsigned K     = 3;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;

    viterbi_traceback_unit_if #(.K(K)) bus ();

    viterbi_traceback_unit #(.K(K), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] dec;       // nibble i = decisions of column i
        bit          use_last;
        bit          zt;
        logic [1:0]  tb;
        logic [7:0]  exp_bits;  // bit i = i-th emitted bit
        bit          exp_ovf;
    } frame_t;

    frame_t tbl [7];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nvalid = 0;
    int drop_cnt = 0;
    int e0 = 0;
    logic got_bit   [512];
    logic got_first [512];
    logic got_last  [512];
    int   got_cyc   [512];

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector
    always @(negedge clk) begin
        if (bus.o_valid && nvalid < 512) begin
            got_bit[nvalid]   = bus.o_bit;
            got_first[nvalid] = bus.o_first;
            got_last[nvalid]  = bus.o_last;
            got_cyc[nvalid]   = cyc;
            nvalid++;
        end
        if (bus.o_drop) drop_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_cols(input int f, output int vbase, output int dbase);
        vbase = nvalid;
        dbase = drop_cnt;
        for (int i = 0; i < tbl[f].n; i++) begin
            @(negedge clk);
            if (i == 1) chk($sformatf("f%0d_ovf_clear", f), int'(bus.o_ovf), 0);
            bus.en_td       = 1'b1;
            bus.i_dec       = tbl[f].dec[i*4 +: 4];
            bus.i_last      = tbl[f].use_last && (i == tbl[f].n - 1);
            bus.i_zero_term = tbl[f].zt;
            bus.i_tb_st     = tbl[f].tb;
        end
        @(negedge clk);
        bus.en_td  = 1'b0;
        bus.i_last = 1'b0;
        e0 = cyc;
        chk($sformatf("f%0d_busy", f), int'(bus.o_busy), 1);
        chk($sformatf("f%0d_ovf", f), int'(bus.o_ovf), int'(tbl[f].exp_ovf));
    endtask

    task automatic drain(input int f, input int vbase, input int dbase, input int pa, input int pb);
        int n;
        n = tbl[f].n;
        for (int k = 1; k <= 2 * n + 6; k++) begin
            @(negedge clk);
            bus.en_td  = (k == pa) || (k == pb);
            bus.i_dec  = 4'hF;
            bus.i_last = 1'b1;
        end
        @(negedge clk);
        bus.en_td  = 1'b0;
        bus.i_last = 1'b0;
        chk($sformatf("f%0d_count", f), nvalid - vbase, n);
        if (nvalid - vbase == n) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("f%0d_bit%0d", f, i), int'(got_bit[vbase+i]), int'(tbl[f].exp_bits[i]));
                chk($sformatf("f%0d_first%0d", f, i), int'(got_first[vbase+i]), (i == 0) ? 1 : 0);
                chk($sformatf("f%0d_last%0d", f, i), int'(got_last[vbase+i]), (i == n - 1) ? 1 : 0);
            end
            chk($sformatf("f%0d_lat_first", f), got_cyc[vbase] - e0, n + 1);
            chk($sformatf("f%0d_lat_last", f), got_cyc[vbase+n-1] - e0, 2 * n);
        end
        chk($sformatf("f%0d_idle_busy", f), int'(bus.o_busy), 0);
        chk($sformatf("f%0d_idle_valid", f), int'(bus.o_valid), 0);
        chk($sformatf("f%0d_drops", f), drop_cnt - dbase, ((pa != 0) ? 1 : 0) + ((pb != 0) ? 1 : 0));
    endtask

    task automatic run_frame(input int f, input int pa, input int pb);
        int vb, db;
        send_cols(f, vb, db);
        drain(f, vb, db, pa, pb);
    endtask

    initial begin
        int vb, db, nv_hold;
        //          n  dec            last zt tb    bits   ovf
        tbl[0] = '{6, 32'h0012_0400, 1'b1, 1'b1, 2'd0, 8'h0D, 1'b0};
        tbl[1] = '{6, 32'h0012_0400, 1'b1, 1'b0, 2'd0, 8'h0D, 1'b0};
        tbl[2] = '{6, 32'h0000_0000, 1'b1, 1'b0, 2'd2, 8'h20, 1'b0};
        tbl[3] = '{1, 32'h0000_0000, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0};
        tbl[4] = '{8, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'd0, 8'h3F, 1'b0};
        tbl[5] = '{8, 32'h0000_0000, 1'b0, 1'b1, 2'd3, 8'hC0, 1'b1};
        tbl[6] = '{6, 32'h0012_0400, 1'b1, 1'b1, 2'd1, 8'h0D, 1'b0};

        rst = 1'b0;
        bus.en_td = 1'b0;
        bus.i_dec = '0;
        bus.i_last = 1'b0;
        bus.i_zero_term = 1'b0;
        bus.i_tb_st = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(bus.o_valid), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_ovf", int'(bus.o_ovf), 0);
        chk("rst_drop", int'(bus.o_drop), 0);
        chk("rst_first_last", int'({bus.o_first, bus.o_last, bus.o_bit}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int f = 0; f < 7; f++) run_frame(f, 0, 0);

        // Column strobes while busy: one during TRACE, one during OUT
        run_frame(0, 3, 9);
        run_frame(2, 0, 0);

        // Reset during OUT aborts the frame
        send_cols(0, vb, db);
        repeat (8) @(negedge clk);
        chk("mid_out_valid", int'(bus.o_valid), 1);
        rst = 1'b0;
        #1;
        chk("abort_valid", int'(bus.o_valid), 0);
        chk("abort_busy", int'(bus.o_busy), 0);
        nv_hold = nvalid;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_more_valid", nvalid - nv_hold, 0);
        run_frame(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/viterbi_traceback_unit.md
Name: viterbi_traceback_unit

Overview:
- Parametrised survivor-memory and traceback unit for the radix-2 Viterbi decoder; sits directly after the add-compare-select array.
- Stores one decision bit per state per trellis column for a frame of up to DEPTH columns.
- On frame end, traces back from a selected state and emits the decoded bits in forward (time) order.
- Generalises the fixed 4-state, 8-deep survivor store to any constraint length and depth, and adds frame control, overflow handling and an output handshake.

Parameters:
- K, 3, constraint length; legal range 3..9. NUM_ST = 2^(K-1) states.
- DEPTH, 64, maximum frame length in columns; must be at least 2.
- AW, clog2(DEPTH), derived localparam; pointer width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_td  in  1  column-valid strobe from the ACS array.
- i_dec  in  NUM_ST  decision bits; bit s is the decision for state s.
- i_last  in  1  marks the current column as the final column of the frame.
- i_zero_term  in  1  sampled with i_last. 1 = start traceback from state 0; 0 = start from i_tb_st.
- i_tb_st  in  K-1  best-metric state, sampled with i_last.
- o_bit  out  1  decoded bit.
- o_valid  out  1  o_bit is valid this cycle.
- o_first  out  1  first bit of the frame; coincident with o_valid.
- o_last  out  1  final bit of the frame; coincident with o_valid.
- o_busy  out  1  high in TRACE and OUT states.
- o_drop  out  1  one-cycle pulse when en_td is ignored.
- o_ovf  out  1  sticky overflow flag for the current frame.

Behaviour:
- Trellis convention: next state = {u, s[K-2:1]}.
  - Predecessor of state s = {s[K-3:0], i_dec[s]}.
  - Decoded bit for a column = MSB of the path state after that column.
- Reset (asynchronous, rst=0):
  - FSM to IDLE; write pointer and frame length to 0.
  - All outputs 0.
  - Any partial frame is discarded. Memory contents need not be cleared.
- FSM states: IDLE/WRITE (one state, called WR), TRACE, OUT.
- WR:
  - en_td=1 writes i_dec into mem[wptr] and increments wptr.
  - If i_last=1: N = wptr+1; start state = 0 if i_zero_term=1, else i_tb_st; go to TRACE.
  - If wptr == DEPTH-1 without i_last: treat the column as last, start from i_tb_st, set o_ovf=1, go to TRACE.
  - A new frame's first write clears o_ovf.
- TRACE, one column per cycle, ptr runs from N-1 down to 0:
  - bitbuf[ptr] <= cur[K-2].
  - cur <= {cur[K-3:0], mem[ptr][cur]}.
  - When ptr == 0, go to OUT.
  - Memory read is combinational from the register array.
- OUT, one bit per cycle, optr runs from 0 to N-1:
  - o_bit <= bitbuf[optr]; o_valid <= 1.
  - o_first <= (optr==0); o_last <= (optr==N-1).
  - After optr == N-1, return to WR; wptr resets to 0.
  - o_valid/o_first/o_last are registered and deassert the cycle after the last bit.
- Latency, with the last column accepted at edge E0:
  - TRACE spans edges E1..EN.
  - o_valid is high after edges EN+1..E2N.
  - A new column is accepted from edge E2N+1 onward.
- Busy and drop rules:
  - o_busy = (state != WR).
  - en_td=1 while o_busy=1: column ignored, o_drop pulses for 1 cycle, nothing stored.
- Single-column frame (i_last on the first column): N=1, TRACE is 1 cycle, OUT is 1 cycle, o_first and o_last both high.
- en_td=0 in WR: no change; i_last is ignored unless en_td=1.
- Reset asserted mid-TRACE or mid-OUT: immediate abort; no further o_valid.

Test Plan:
- K=3. Columns i_dec = 0000, 0000, 0100, 0000, 0010, 0001; i_last on column 6; i_zero_term=1 -> after 6 TRACE cycles, o_bit = 1,0,1,1,0,0 on 6 consecutive o_valid cycles; o_first on bit 1, o_last on bit 6.
- Same frame with i_zero_term=0, i_tb_st=0 -> identical output. Then i_tb_st=2 with all-zero decisions -> output 0,0,0,0,0,1.
- DEPTH=8, 8 columns without i_last -> o_ovf=1 after column 8; 8 bits output; o_ovf clears on the next frame's first write.
- en_td pulses during TRACE and during OUT -> o_drop pulses once per pulse; the next frame decodes correctly.
- Single column, i_dec=0000, i_zero_term=1 -> one o_valid with o_bit=0, o_first=o_last=1.
- rst low for 1 cycle during OUT of a 6-bit frame -> o_valid=0 immediately; o_busy=0; the next frame decodes correctly.
